// File: rtl/bpred_branch_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bpred_branch_tracker
// Description : Front end of the 2-bit counter table in the branch predictor.
//               Forms the counter-table lookup index from the DEC-stage PC.
//               Keeps {index, prediction} for each in-flight branch in a
//               small FIFO. When the ALU resolves a branch it pops the oldest
//               entry and emits a registered counter-table update plus a
//               mispredict flag.
//
// Parameters  : BPRED_WIDTH - counter-table index width (2**BPRED_WIDTH ctrs)
//               DEPTH       - max branches in flight, power of two, >= 2
//
// Ports       : i_Clk, i_Reset          - clock, synchronous active-high reset
//               i_DEC_PC                - PC of the instruction in DEC
//               i_DEC_Is_Branch         - push request (conditional branch)
//               i_Prediction            - table prediction for o_Lookup_Index
//               i_ALU_Branch_Valid      - pop request (oldest branch resolves)
//               i_ALU_Branch_Outcome    - resolved direction (1 = taken)
//               i_Flush                 - squash all queued branches
//               o_Lookup_Index          - combinational table read index
//               o_Index                 - update index when updating, else
//                                         lookup index
//               o_Update_Enable/_Index/_Outcome, o_Mispredict
//                                       - registered one-cycle update pulse
//               o_Count, o_Full, o_Empty- FIFO occupancy
//               o_Overflow, o_Underflow - registered error pulses
//
// Options     : `define BPRED_GSHARE_EN to XOR the index with a
//               non-speculative global history register (gshare); otherwise
//               the index is the plain word-aligned PC bits (bimodal).
//
// Revision    : 1.0 - initial release
// ============================================================================
module bpred_branch_tracker #(
    parameter int BPRED_WIDTH = 9,
    parameter int DEPTH       = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic [31:0]              i_DEC_PC,
    input  logic                     i_DEC_Is_Branch,
    input  logic                     i_Prediction,
    input  logic                     i_ALU_Branch_Valid,
    input  logic                     i_ALU_Branch_Outcome,
    input  logic                     i_Flush,
    output logic [BPRED_WIDTH-1:0]   o_Lookup_Index,
    output logic [BPRED_WIDTH-1:0]   o_Index,
    output logic                     o_Update_Enable,
    output logic [BPRED_WIDTH-1:0]   o_Update_Index,
    output logic                     o_Update_Outcome,
    output logic                     o_Mispredict,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic                     o_Overflow,
    output logic                     o_Underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    // Entry storage; contents need no reset because occupancy is tracked
    // separately by the pointers and count.
    logic [BPRED_WIDTH-1:0] r_idx_mem [DEPTH];
    logic [DEPTH-1:0]       r_pred_mem;

    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic                   r_upd_en;
    logic [BPRED_WIDTH-1:0] r_upd_idx;
    logic                   r_upd_out;
    logic                   r_mispred;
    logic                   r_ovf;
    logic                   r_udf;

    logic [BPRED_WIDTH-1:0] w_base;
    logic [BPRED_WIDTH-1:0] w_lookup;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push_req;
    logic                   w_push;
    logic [BPRED_WIDTH-1:0] w_rd_idx;
    logic                   w_rd_pred;
    logic                   w_unused_pc;

    // Word-aligned PC bits select the counter; the rest of the PC is ignored.
    assign w_base      = i_DEC_PC[BPRED_WIDTH+1:2];
    assign w_unused_pc = ^{i_DEC_PC[31:BPRED_WIDTH+2], i_DEC_PC[1:0]};

    assign w_full     = (r_count == c_FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = i_ALU_Branch_Valid & ~w_empty;
    assign w_push_req = i_DEC_Is_Branch & ~i_Flush;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_push     = w_push_req & (~w_full | w_pop);

    assign w_rd_idx   = r_idx_mem[r_rd_ptr];
    assign w_rd_pred  = r_pred_mem[r_rd_ptr];

`ifdef BPRED_GSHARE_EN
    // History is trained only at resolution, so flushes never disturb it.
    logic [BPRED_WIDTH-1:0] r_ghr;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_ghr <= '0;
        end else if (w_pop) begin
            r_ghr <= {r_ghr[BPRED_WIDTH-2:0], i_ALU_Branch_Outcome};
        end
    end

    assign w_lookup = w_base ^ r_ghr;
`else
    assign w_lookup = w_base;
`endif

    // Write side. When full with a simultaneous pop, the write pointer equals
    // the read pointer; the read above sees the old entry before this edge.
    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_idx_mem[r_wr_ptr]  <= w_lookup;
            r_pred_mem[r_wr_ptr] <= i_Prediction;
        end
    end

    // Pointers and occupancy. Flush wins over push/pop bookkeeping, but the
    // popped entry has already been captured into the update registers.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Registered update and status pulses.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_upd_en  <= 1'b0;
            r_upd_idx <= '0;
            r_upd_out <= 1'b0;
            r_mispred <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_upd_en  <= w_pop;
            r_mispred <= w_pop & (w_rd_pred != i_ALU_Branch_Outcome);
            if (w_pop) begin
                r_upd_idx <= w_rd_idx;
                r_upd_out <= i_ALU_Branch_Outcome;
            end
            r_ovf     <= w_push_req & w_full & ~w_pop;
            r_udf     <= i_ALU_Branch_Valid & w_empty;
        end
    end

    assign o_Lookup_Index   = w_lookup;
    assign o_Index          = r_upd_en ? r_upd_idx : w_lookup;
    assign o_Update_Enable  = r_upd_en;
    assign o_Update_Index   = r_upd_idx;
    assign o_Update_Outcome = r_upd_out;
    assign o_Mispredict     = r_mispred;
    assign o_Count          = r_count;
    assign o_Full           = w_full;
    assign o_Empty          = w_empty;
    assign o_Overflow       = r_ovf;
    assign o_Underflow      = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_bpred_branch_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpred_branch_tracker
// Description : Self-checking bench for bpred_branch_tracker. Resolves are
//               pushed to a scoreboard of expected updates; a monitor pops
//               and compares whenever the DUT emits an update pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpred_branch_tracker;

    localparam int BPRED_WIDTH = 9;
    localparam int DEPTH       = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dec_pc;
    logic        is_br, pred, alu_valid, alu_out, flush;
    logic [8:0]  lookup_idx, idx, upd_idx;
    logic        upd_en, upd_out, mispred, full, empty, ovf, udf;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [8:0] idx;
        logic       out;
        logic       mis;
        int         due;
    } upd_t;

    typedef struct {
        logic [8:0] idx;
        logic       pred;
    } ent_t;

    upd_t       sb[$];
    ent_t       mf[$];
    logic [8:0] m_ghr;

    bpred_branch_tracker #(
        .BPRED_WIDTH (BPRED_WIDTH),
        .DEPTH       (DEPTH)
    ) dut (
        .i_Clk                (clk),
        .i_Reset              (rst),
        .i_DEC_PC             (dec_pc),
        .i_DEC_Is_Branch      (is_br),
        .i_Prediction         (pred),
        .i_ALU_Branch_Valid   (alu_valid),
        .i_ALU_Branch_Outcome (alu_out),
        .i_Flush              (flush),
        .o_Lookup_Index       (lookup_idx),
        .o_Index              (idx),
        .o_Update_Enable      (upd_en),
        .o_Update_Index       (upd_idx),
        .o_Update_Outcome     (upd_out),
        .o_Mispredict         (mispred),
        .o_Count              (count),
        .o_Full               (full),
        .o_Empty              (empty),
        .o_Overflow           (ovf),
        .o_Underflow          (udf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] exp_lookup(input logic [31:0] pc);
`ifdef BPRED_GSHARE_EN
        return pc[10:2] ^ m_ghr;
`else
        return pc[10:2];
`endif
    endfunction

    // Scoreboard monitor: every update pulse must match the oldest expected
    // update and appear exactly one cycle after its resolve.
    upd_t mu;
    always @(negedge clk) begin
        if (!rst && upd_en === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: update idx=%0d seen, none expected", upd_idx);
            end else begin
                mu = sb.pop_front();
                if (upd_idx !== mu.idx || upd_out !== mu.out || mispred !== mu.mis || cyc != mu.due) begin
                    bad++;
                    $display("FAIL sb_update: got idx=%0d out=%0b mis=%0b cyc=%0d, want idx=%0d out=%0b mis=%0b cyc=%0d",
                             upd_idx, upd_out, mispred, cyc, mu.idx, mu.out, mu.mis, mu.due);
                end
            end
        end else if (!rst && sb.size() > 0 && sb[0].due <= cyc) begin
            total++;
            bad++;
            $display("FAIL sb_missing: no update at cyc=%0d, want idx=%0d", cyc, sb[0].idx);
            void'(sb.pop_front());
        end
    end

    // Apply one cycle of stimulus, advance the reference model, then step to
    // just after the next rising edge.
    task automatic drive(input logic [31:0] pc, input logic br, input logic p,
                         input logic v, input logic o, input logic fl);
        ent_t       e;
        upd_t       u;
        logic [8:0] push_idx;
        logic       popped;
        logic       was_full;
        dec_pc = pc; is_br = br; pred = p; alu_valid = v; alu_out = o; flush = fl;
        #1;
        push_idx = exp_lookup(pc);
        total++;
        if (lookup_idx !== push_idx) begin
            bad++;
            $display("FAIL lookup_idx: got %0d want %0d", lookup_idx, push_idx);
        end
        if (upd_en === 1'b0) begin
            total++;
            if (idx !== push_idx) begin
                bad++;
                $display("FAIL index_mux: got %0d want %0d", idx, push_idx);
            end
        end
        popped   = v && (mf.size() > 0);
        was_full = (mf.size() == DEPTH);
        if (popped) begin
            e     = mf.pop_front();
            u.idx = e.idx;
            u.out = o;
            u.mis = (e.pred != o);
            u.due = cyc + 1;
            sb.push_back(u);
`ifdef BPRED_GSHARE_EN
            m_ghr = {m_ghr[7:0], o};
`endif
        end
        if (fl) begin
            mf.delete();
        end else if (br && (!was_full || popped)) begin
            e.idx  = push_idx;
            e.pred = p;
            mf.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dec_pc = '0; is_br = 0; pred = 0; alu_valid = 0; alu_out = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mf.delete();
        sb.delete();
        m_ghr = '0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || upd_en !== 1'b0 ||
            ovf !== 1'b0 || udf !== 1'b0 || upd_idx !== 9'd0 || upd_out !== 1'b0 || mispred !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: count=%0d empty=%0b full=%0b upd=%0b ovf=%0b udf=%0b uidx=%0d, want 0 1 0 0 0 0 0",
                     count, empty, full, upd_en, ovf, udf, upd_idx);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (count !== 3'd1 || empty !== 1'b0) begin
            bad++;
            $display("FAIL single_count: got count=%0d empty=%0b want 1 0", count, empty);
        end
        idle();
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (upd_en !== 1'b1 || upd_idx !== 9'd4 || upd_out !== 1'b0 || mispred !== 1'b1 ||
            idx !== 9'd4 || count !== 3'd0) begin
            bad++;
            $display("FAIL single_update: got en=%0b idx=%0d out=%0b mis=%0b oidx=%0d count=%0d want 1 4 0 1 4 0",
                     upd_en, upd_idx, upd_out, mispred, idx, count);
        end
        idle();
        total++;
        if (upd_en !== 1'b0 || mispred !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse: got en=%0b mis=%0b want 0 0", upd_en, mispred);
        end
    endtask

    task automatic test_ordering();
        do_reset();
        drive(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (upd_idx !== 9'd4 || mispred !== 1'b0 || upd_en !== 1'b1) begin
            bad++;
            $display("FAIL order_first: got idx=%0d mis=%0b want 4 0", upd_idx, mispred);
        end
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (upd_idx !== 9'd8 || mispred !== 1'b0 || upd_en !== 1'b1) begin
            bad++;
            $display("FAIL order_second: got idx=%0d mis=%0b want 8 0", upd_idx, mispred);
        end
        idle();
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(32'h100 + 32'(i * 4), 1'b1, i[0], 1'b0, 1'b0, 1'b0);
        end
        total++;
        if (full !== 1'b1 || count !== 3'd4 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL full_flag: got full=%0b count=%0d ovf=%0b want 1 4 0", full, count, ovf);
        end
        drive(32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (ovf !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL overflow: got ovf=%0b count=%0d want 1 4", ovf, count);
        end
        idle();
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL overflow_pulse: got ovf=%0b want 0", ovf);
        end
        drive(32'h300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (count !== 3'd4 || ovf !== 1'b0 || full !== 1'b1 || upd_en !== 1'b1) begin
            bad++;
            $display("FAIL full_push_pop: got count=%0d ovf=%0b full=%0b upd=%0b want 4 0 1 1", count, ovf, full, upd_en);
        end
        // Drain across the pointer wrap; the scoreboard checks the order.
        for (int i = 0; i < 4; i++) begin
            drive(32'h0, 1'b0, 1'b0, 1'b1, i[1], 1'b0);
        end
        total++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL drain: got count=%0d empty=%0b want 0 1", count, empty);
        end
        idle();
    endtask

    task automatic test_underflow_flush();
        do_reset();
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (udf !== 1'b1 || upd_en !== 1'b0) begin
            bad++;
            $display("FAIL underflow: got udf=%0b upd=%0b want 1 0", udf, upd_en);
        end
        idle();
        total++;
        if (udf !== 1'b0) begin
            bad++;
            $display("FAIL underflow_pulse: got udf=%0b want 0", udf);
        end
        drive(32'h60, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (udf !== 1'b1 || count !== 3'd1 || upd_en !== 1'b0) begin
            bad++;
            $display("FAIL empty_push_pop: got udf=%0b count=%0d upd=%0b want 1 1 0", udf, count, upd_en);
        end
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(32'h48, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL pre_flush_count: got %0d want 3", count);
        end
        drive(32'h50, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (upd_en !== 1'b1 || upd_idx !== 9'd16 || mispred !== 1'b1 || count !== 3'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL flush_pop: got upd=%0b idx=%0d mis=%0b count=%0d empty=%0b want 1 16 1 0 1",
                     upd_en, upd_idx, mispred, count, empty);
        end
        idle();
        total++;
        if (upd_en !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL post_flush: got upd=%0b count=%0d want 0 0", upd_en, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(32'h70, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(32'h74, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        total++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: got count=%0d empty=%0b want 0 1", count, empty);
        end
        // Resolves now hit an empty FIFO: underflow, no stale update.
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (udf !== 1'b1 || upd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_discard: got udf=%0b upd=%0b want 1 0", udf, upd_en);
        end
        idle();
    endtask

    task automatic test_gshare();
        logic [8:0] want;
        do_reset();
        drive(32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(32'h84, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef BPRED_GSHARE_EN
        want = 9'd7;
`else
        want = 9'd4;
`endif
        dec_pc = 32'h10;
        #1;
        total++;
        if (lookup_idx !== want) begin
            bad++;
            $display("FAIL gshare_lookup: got %0d want %0d", lookup_idx, want);
        end
        drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (upd_idx !== want || mispred !== 1'b0) begin
            bad++;
            $display("FAIL gshare_stored: got idx=%0d mis=%0b want %0d 0", upd_idx, mispred, want);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        dec_pc = '0; is_br = 0; pred = 0; alu_valid = 0; alu_out = 0; flush = 0;
        m_ghr = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_ordering();
        test_full_overflow();
        test_underflow_flush();
        test_reset_mid();
        test_gshare();
        repeat (2) idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
